// File: rtl/rom_dl_pkg.sv
// Shared constants for the ROM download path: region map, image size and
// the sequencer state encoding.
package rom_dl_pkg;

    typedef enum logic [2:0] {
        EP1 = 3'd0,
        EP2 = 3'd1,
        EP3 = 3'd2,
        EP4 = 3'd3,
        EP5 = 3'd4,
        CP1 = 3'd5,
        CP2 = 3'd6,
        CP3 = 3'd7
    } region_e;

    localparam int NUM_REGIONS = int'(CP3) + 1;

    localparam logic [31:0] TOTAL = 32'h0002_8600;

    localparam logic [31:0] REGION_BASE [NUM_REGIONS] = '{
        32'h0000_0000, 32'h0000_8000, 32'h0001_0000, 32'h0001_8000,
        32'h0002_0000, 32'h0002_8000, 32'h0002_8200, 32'h0002_8400
    };

    localparam logic [31:0] REGION_LAST [NUM_REGIONS] = '{
        32'h0000_7FFF, 32'h0000_FFFF, 32'h0001_7FFF, 32'h0001_FFFF,
        32'h0002_7FFF, 32'h0002_81FF, 32'h0002_83FF, 32'h0002_85FF
    };

    // Exclusive upper bound of each region; cp3 stops at TOTAL rather than
    // swallowing every address above it.
    localparam logic [31:0] REGION_END [NUM_REGIONS] = '{
        32'h0000_8000, 32'h0001_0000, 32'h0001_8000, 32'h0002_0000,
        32'h0002_8000, 32'h0002_8200, 32'h0002_8400, TOTAL
    };

    // Sequencer states; encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational byte address -> one-hot ROM region select, plus flags for
// "last byte of its region" and "inside the image".
module rom_region_decode
    import rom_dl_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        cs,
    output logic              is_last,
    output logic              in_range
);

    logic [31:0] a32;

    assign a32 = 32'(addr);

    always_comb begin
        cs       = '0;
        is_last  = 1'b0;
        in_range = (a32 < TOTAL);
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if ((a32 >= REGION_BASE[i]) && (a32 < REGION_END[i]))
                cs[i] = 1'b1;
            if (a32 == REGION_LAST[i])
                is_last = 1'b1;
        end
    end

endmodule

// File: rtl/rom_dl_sequencer.sv
// Download-clock sequencer: forwards the ioctl ROM stream to the region RAMs,
// checks ordering/size, and releases the game core only after a clean load.
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int ROM_INDEX = 0,
    parameter int ADDR_W    = 25
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] dl_addr,
    output logic [7:0]        dl_data,
    output logic              dl_wr,
    output logic [7:0]        dl_cs,
    output logic [7:0]        region_loaded,
    output logic [15:0]       checksum,
    output logic              core_reset,
    output logic              dl_busy,
    output logic              err_seq,
    output logic              err_oob,
    output logic              err_short,
    output logic [2:0]        dbg_state
);

    // Handshake: ioctl_wr is a one-cycle strobe with no back-pressure; every
    // accepted strobe in LOAD yields exactly one dl_wr pulse one cycle later.

    state_e            state;
    logic [ADDR_W-1:0] next_addr;
    logic              dl_prev;
    logic [7:0]        dec_cs;
    logic              dec_last;
    logic              dec_in_range;
    logic              start;

    rom_region_decode #(.ADDR_W(ADDR_W)) u_decode (
        .addr     (ioctl_addr),
        .cs       (dec_cs),
        .is_last  (dec_last),
        .in_range (dec_in_range)
    );

    assign start     = ioctl_download && !dl_prev && (ioctl_index == 8'(ROM_INDEX));
    assign dl_busy   = (state == ST_LOAD) || (state == ST_CHECK);
    assign dbg_state = state;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ST_IDLE;
            next_addr     <= '0;
            // Treat the download line as already high so a transfer that was
            // in flight across reset is not mistaken for a fresh start.
            dl_prev       <= 1'b1;
            dl_addr       <= '0;
            dl_data       <= '0;
            dl_wr         <= 1'b0;
            dl_cs         <= '0;
            region_loaded <= '0;
            checksum      <= '0;
            core_reset    <= 1'b1;
            err_seq       <= 1'b0;
            err_oob       <= 1'b0;
            err_short     <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            dl_wr   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (state == ST_DONE)
                        core_reset <= 1'b0;
                    if (start) begin
                        state         <= ST_LOAD;
                        next_addr     <= '0;
                        region_loaded <= '0;
                        checksum      <= '0;
                        err_seq       <= 1'b0;
                        err_oob       <= 1'b0;
                        err_short     <= 1'b0;
                        core_reset    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ioctl_wr) begin
                        if (!dec_in_range) begin
                            err_oob <= 1'b1;
                        end else begin
                            dl_addr       <= ioctl_addr;
                            dl_data       <= ioctl_dout;
                            dl_cs         <= dec_cs;
                            dl_wr         <= 1'b1;
                            checksum      <= checksum + 16'(ioctl_dout);
                            region_loaded <= region_loaded | (dec_cs & {8{dec_last}});
                            next_addr     <= ioctl_addr + 1'b1;
                            if (ioctl_addr != next_addr)
                                err_seq <= 1'b1;
                        end
                    end
                    if (!ioctl_download)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    dl_cs     <= '0;
                    err_short <= (next_addr != ADDR_W'(TOTAL));
                    if (err_seq || err_oob || (next_addr != ADDR_W'(TOTAL)))
                        state <= ST_ERROR;
                    else
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: linear sequence of download scenarios
// with hand-computed expectations checked by immediate assertions.
module tb_rom_dl_sequencer;

    localparam int ADDR_W = 25;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wr;
    logic [7:0]        dl_cs;
    logic [7:0]        region_loaded;
    logic [15:0]       checksum;
    logic              core_reset;
    logic              dl_busy;
    logic              err_seq;
    logic              err_oob;
    logic              err_short;
    logic [2:0]        dbg_state;

    int compared   = 0;
    int mismatched = 0;

    rom_dl_sequencer #(.ROM_INDEX(0), .ADDR_W(ADDR_W)) dut (
        .CLK            (clk),
        .RESET_N        (rst_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_wr          (dl_wr),
        .dl_cs          (dl_cs),
        .region_loaded  (region_loaded),
        .checksum       (checksum),
        .core_reset     (core_reset),
        .dl_busy        (dl_busy),
        .err_seq        (err_seq),
        .err_oob        (err_oob),
        .err_short      (err_short),
        .dbg_state      (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_download();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    initial begin
        int fwd_bad;
        rst_n          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'd0;
        tick();
        tick();

        // Reset state
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_dl_wr", 32'(dl_wr), 32'd0);
        check("rst_dl_addr", 32'(dl_addr), 32'd0);
        check("rst_dl_cs", 32'(dl_cs), 32'd0);
        check("rst_loaded", 32'(region_loaded), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_errs", {29'd0, err_seq, err_oob, err_short}, 32'd0);
        check("rst_busy", 32'(dl_busy), 32'd0);

        rst_n = 1'b1;
        tick();

        // Skipped address: 0x00..0x0E then 0x10
        start_download(8'd0);
        check("seq_state_load", 32'(dbg_state), 32'(S_LOAD));
        check("seq_busy", 32'(dl_busy), 32'd1);
        for (int a = 0; a <= 14; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = ADDR_W'(a);
            ioctl_dout = 8'(a);
            tick();
        end
        check("seq_no_err_yet", 32'(err_seq), 32'd0);
        write_byte(25'h10, 8'h10);
        check("seq_dl_wr", 32'(dl_wr), 32'd1);
        check("seq_dl_addr", 32'(dl_addr), 32'h10);
        check("seq_dl_data", 32'(dl_data), 32'h10);
        check("seq_err_seq", 32'(err_seq), 32'd1);
        end_download();
        check("seq_state_check", 32'(dbg_state), 32'(S_CHECK));
        tick();
        check("seq_state_error", 32'(dbg_state), 32'(S_ERROR));
        check("seq_core_reset", 32'(core_reset), 32'd1);
        check("seq_checksum", 32'(checksum), 32'h79);
        check("seq_err_short", 32'(err_short), 32'd1);

        // Download with another index is ignored
        start_download(8'd1);
        check("idx1_state", 32'(dbg_state), 32'(S_ERROR));
        write_byte(25'h0, 8'h55);
        check("idx1_no_wr", 32'(dl_wr), 32'd0);
        check("idx1_checksum", 32'(checksum), 32'h79);
        end_download();
        tick();
        check("idx1_state_after", 32'(dbg_state), 32'(S_ERROR));
        check("idx1_core_reset", 32'(core_reset), 32'd1);

        // Full sequential load from ERROR, back-to-back writes
        start_download(8'd0);
        check("full_state_load", 32'(dbg_state), 32'(S_LOAD));
        check("full_flags_cleared", {26'd0, err_seq, err_oob, err_short, 3'd0}, 32'd0);
        check("full_checksum_cleared", 32'(checksum), 32'd0);
        fwd_bad = 0;
        for (int a = 0; a < 32'h28600; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = ADDR_W'(a);
            ioctl_dout = 8'(a);
            tick();
            if (dl_wr !== 1'b1 || dl_addr !== ADDR_W'(a) || dl_data !== 8'(a))
                fwd_bad++;
            if (a == 32'h07FFF) begin
                check("cs_07fff", 32'(dl_cs), 32'h01);
                check("loaded_07fff", 32'(region_loaded), 32'h01);
            end
            if (a == 32'h08000) begin
                check("cs_08000", 32'(dl_cs), 32'h02);
                check("loaded_08000", 32'(region_loaded), 32'h01);
            end
            if (a == 32'h281FF) check("cs_281ff", 32'(dl_cs), 32'h20);
            if (a == 32'h28200) check("cs_28200", 32'(dl_cs), 32'h40);
            if (a == 32'h285FF) check("cs_285ff", 32'(dl_cs), 32'h80);
        end
        check("full_forward_all", 32'(fwd_bad), 32'd0);
        end_download();
        check("full_dl_wr_off", 32'(dl_wr), 32'd0);
        check("full_state_check", 32'(dbg_state), 32'(S_CHECK));
        check("full_cr_check", 32'(core_reset), 32'd1);
        check("full_busy_check", 32'(dl_busy), 32'd1);
        tick();
        check("full_state_done", 32'(dbg_state), 32'(S_DONE));
        check("full_cr_done1", 32'(core_reset), 32'd1);
        check("full_busy_done", 32'(dl_busy), 32'd0);
        check("full_cs_cleared", 32'(dl_cs), 32'd0);
        tick();
        check("full_cr_done2", 32'(core_reset), 32'd0);
        check("full_loaded", 32'(region_loaded), 32'hFF);
        check("full_checksum", 32'(checksum), 32'hBD00);
        check("full_errs", {29'd0, err_seq, err_oob, err_short}, 32'd0);

        // Out-of-bounds write
        start_download(8'd0);
        check("oob_core_reset", 32'(core_reset), 32'd1);
        write_byte(25'h28600, 8'hAA);
        check("oob_no_wr", 32'(dl_wr), 32'd0);
        check("oob_err", 32'(err_oob), 32'd1);
        check("oob_checksum", 32'(checksum), 32'd0);
        end_download();
        tick();
        check("oob_state", 32'(dbg_state), 32'(S_ERROR));

        // Short download: 0x000..0x1FF only
        start_download(8'd0);
        for (int a = 0; a < 512; a++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = ADDR_W'(a);
            ioctl_dout = 8'(a);
            tick();
        end
        end_download();
        tick();
        check("short_state", 32'(dbg_state), 32'(S_ERROR));
        check("short_errs", {29'd0, err_seq, err_oob, err_short}, 32'd1);
        check("short_loaded", 32'(region_loaded), 32'd0);

        // Write outside LOAD is ignored
        write_byte(25'h200, 8'h77);
        check("idle_wr_ignored", 32'(dl_wr), 32'd0);
        check("idle_checksum", 32'(checksum), 32'hFF00);

        // Asynchronous reset mid-LOAD
        start_download(8'd0);
        write_byte(25'h12345, 8'h45);
        check("mid_dl_wr", 32'(dl_wr), 32'd1);
        check("mid_dl_addr", 32'(dl_addr), 32'h12345);
        check("mid_dl_data", 32'(dl_data), 32'h45);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        check("arst_dl_addr", 32'(dl_addr), 32'd0);
        check("arst_dl_data", 32'(dl_data), 32'd0);
        check("arst_dl_wr", 32'(dl_wr), 32'd0);
        check("arst_core_reset", 32'(core_reset), 32'd1);
        check("arst_checksum", 32'(checksum), 32'd0);
        check("arst_errs", {29'd0, err_seq, err_oob, err_short}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        write_byte(25'h12346, 8'h46);
        check("post_rst_no_wr", 32'(dl_wr), 32'd0);
        check("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("post_rst_checksum", 32'(checksum), 32'd0);
        end_download();
        start_download(8'd0);
        check("post_rst_restart", 32'(dbg_state), 32'(S_LOAD));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
